wb_accel_wrapper: RTL
=====================

WB_ACCEL_WRAPPER -- requirements
Module: wb_accel_wrapper

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, bus/core word width, multiple of 8, at least 32.
REQ-002 Parameters SHALL be: ADDR_WIDTH, default 32, Wishbone address width.
REQ-003 Parameters SHALL be: IN_WORDS, default 4, core operand words, 1..16.
REQ-004 Parameters SHALL be: OUT_WORDS, default 4, core result words, 1..16.
REQ-005 Parameters SHALL be: TIMEOUT_CYCLES, default 1024, RUN watchdog limit, at least 2.
REQ-006 One clock; reset is asynchronous and active-low: clk in 1, system clock; rst_sys_n in 1, async active-low reset.
REQ-007 wb_adr_i in ADDR_WIDTH; wb_dat_i in DATA_WIDTH; wb_sel_i in DATA_WIDTH/8; wb_cyc_i, wb_stb_i, wb_we_i in 1 each; wb_cti_i in 3; wb_bte_i in 2 (Wishbone B3 slave inputs).
REQ-008 wb_dat_o out DATA_WIDTH; wb_ack_o, wb_err_o, wb_rty_o out 1 each (slave responses).
REQ-009 irq_o out 1, level interrupt; core_start_o out 1, one-cycle start pulse; core_din_o out IN_WORDS*DATA_WIDTH, operand words, word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 core_done_i in 1, one-cycle completion pulse; core_dout_i in OUT_WORDS*DATA_WIDTH, result, valid when core_done_i is high.

Function
REQ-011 Decode SHALL use byte offset wb_adr_i[7:0]: 0x00 CTRL, 0x04 STATUS, 0x40+4i IN[i], 0x80+4i OUT[i].
REQ-012 CTRL SHALL have bit0 START (write-1 pulse), bit1 IRQ_EN (read/write), bit2 CLR (write-1 pulse); all reads of START and CLR SHALL return 0.
REQ-013 STATUS (read-only) SHALL have bit0 BUSY, bit1 DONE, bit2 TIMEOUT.
REQ-014 Each access SHALL be answered by exactly one of ack/err/rty, registered, asserted one cycle after cyc&stb and held one cycle; the response SHALL drop for one cycle before the next access is answered.
REQ-015 Writes SHALL honour wb_sel_i per byte; wb_cti_i and wb_bte_i SHALL be ignored, with every access treated as classic.
REQ-016 err SHALL be returned for an unmapped offset, an IN index >= IN_WORDS, an OUT index >= OUT_WORDS, or any write to STATUS/OUT; state SHALL be unchanged.
REQ-017 rty SHALL be returned for an IN write while BUSY; IN SHALL be unchanged.
REQ-018 FSM states: IDLE, RUN, DONE.
REQ-019 START in IDLE or DONE SHALL move the FSM to RUN, clear DONE/TIMEOUT, zero the watchdog, and assert core_start_o for exactly one cycle, in the cycle after the ack.
REQ-020 START in RUN SHALL be acked with no effect.
REQ-021 In RUN, core_done_i SHALL latch core_dout_i into OUT[], move the FSM to DONE and set DONE.
REQ-022 In RUN, the watchdog reaching TIMEOUT_CYCLES SHALL move the FSM to DONE, set DONE and TIMEOUT, and leave OUT[] unchanged.
REQ-023 If core_done_i and the watchdog expire in the same cycle, core_done_i SHALL win (TIMEOUT=0).
REQ-024 CLR in DONE SHALL move the FSM to IDLE and clear DONE and TIMEOUT; if START and CLR are written together, START SHALL win.
REQ-025 core_done_i outside RUN SHALL be ignored.
REQ-026 irq_o SHALL equal DONE & IRQ_EN, combinationally from registers.
REQ-027 core_din_o SHALL reflect IN[] continuously.
REQ-028 BUSY SHALL be 1 exactly in RUN.

Reset
REQ-029 rst_sys_n low SHALL asynchronously force: FSM to IDLE; CTRL, STATUS, IN[], OUT[] and the watchdog to 0; wb_ack_o, wb_err_o, wb_rty_o, irq_o and core_start_o to 0; wb_dat_o to 0.
REQ-030 Reset asserted during RUN SHALL abort the operation; a core_done_i arriving after reset release SHALL be ignored.

Configuration
REQ-031 With macro WB_ACCEL_WATCHDOG_EN defined, REQ-022 SHALL apply; without it, the watchdog logic SHALL be absent, TIMEOUT SHALL read 0, and RUN SHALL wait indefinitely for core_done_i.

Verification
REQ-032 Write IN[0..3]=0x11,0x22,0x33,0x44, then CTRL=0x3 -> core_start_o pulses one cycle, core_din_o word0=0x11, BUSY=1.
REQ-033 Core returns core_done_i with core_dout_i words 0xA0..0xA3 -> STATUS=0x2, irq_o=1, OUT[2] reads 0xA2; then CTRL=0x4 -> STATUS=0x0, irq_o=0.
REQ-034 Writes to 0x04, 0x80 and 0x40+4*IN_WORDS -> wb_err_o each; IN write during RUN -> wb_rty_o, IN unchanged.
REQ-035 With TIMEOUT_CYCLES=16, WB_ACCEL_WATCHDOG_EN defined and no core_done_i -> STATUS=0x6 after 16 RUN cycles; with core_done_i on the expiry cycle -> STATUS=0x2.
REQ-036 Reset asserted mid-RUN, then core_done_i after release -> STATUS=0x0, OUT all 0, all outputs 0.
REQ-037 Byte write IN[1] with sel=0b0010, data=0xFFFFFFFF, over 0 -> IN[1] reads 0x0000FF00.

Source files
------------

// File: rtl/wb_accel_wrapper.sv
// ---------------------------------------------------------------------------
// wb_accel_wrapper
//
// Purpose:
//   Wishbone B3 slave wrapper around a start/done style accelerator core.
//   It exposes a control register, a status register, an operand bank IN[]
//   driven continuously to the core, and a result bank OUT[] captured from
//   the core on completion. Every bus access is treated as a classic cycle
//   and is answered by exactly one registered ack, err or rty pulse.
//
// Register map (byte offset wb_adr_i[7:0]):
//   0x00        CTRL   bit0 START (write-1 pulse), bit1 IRQ_EN, bit2 CLR
//   0x04        STATUS bit0 BUSY, bit1 DONE, bit2 TIMEOUT (read-only)
//   0x40 + 4*i  IN[i]  operand word, i < IN_WORDS  (rty when written while BUSY)
//   0x80 + 4*i  OUT[i] result word, i < OUT_WORDS (read-only)
//
// Optional feature:
//   WB_ACCEL_WATCHDOG_EN -- when defined, a RUN watchdog ends the operation
//   after TIMEOUT_CYCLES cycles and sets TIMEOUT. When undefined, the
//   watchdog is absent, TIMEOUT reads 0 and RUN waits for core_done_i.
//
// Ports:
//   clk, rst_sys_n           clock, asynchronous active-low reset
//   wb_adr_i .. wb_bte_i     Wishbone slave inputs (cti/bte ignored)
//   wb_dat_o, wb_ack_o,
//   wb_err_o, wb_rty_o       Wishbone slave responses
//   irq_o                    level interrupt, DONE & IRQ_EN
//   core_start_o             one-cycle start pulse to the core
//   core_din_o               IN[] packed, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   core_done_i              one-cycle completion pulse from the core
//   core_dout_i              OUT[] packed, valid with core_done_i
// ---------------------------------------------------------------------------
module wb_accel_wrapper #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int IN_WORDS       = 4,
  parameter int OUT_WORDS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_sys_n,
  input  logic [ADDR_WIDTH-1:0]           wb_adr_i,
  input  logic [DATA_WIDTH-1:0]           wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0]         wb_sel_i,
  input  logic                            wb_cyc_i,
  input  logic                            wb_stb_i,
  input  logic                            wb_we_i,
  input  logic [2:0]                      wb_cti_i,
  input  logic [1:0]                      wb_bte_i,
  output logic [DATA_WIDTH-1:0]           wb_dat_o,
  output logic                            wb_ack_o,
  output logic                            wb_err_o,
  output logic                            wb_rty_o,
  output logic                            irq_o,
  output logic                            core_start_o,
  output logic [IN_WORDS*DATA_WIDTH-1:0]  core_din_o,
  input  logic                            core_done_i,
  input  logic [OUT_WORDS*DATA_WIDTH-1:0] core_dout_i
);

  localparam int SEL_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    irq_en_q, irq_en_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;
  logic                    start_pend_q, start_pend_d;
  logic                    core_start_q, core_start_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    rty_q, rty_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [DATA_WIDTH-1:0]   in_q  [IN_WORDS];
  logic [DATA_WIDTH-1:0]   in_d  [IN_WORDS];
  logic [DATA_WIDTH-1:0]   out_q [OUT_WORDS];
  logic [DATA_WIDTH-1:0]   out_d [OUT_WORDS];

  // Bus decode signals
  logic                    req;
  logic [7:0]              off;
  logic [3:0]              idx;
  logic                    is_ctrl, is_stat, is_in, is_out;
  logic                    bad_acc, in_busy_wr;
  logic                    wr_ok, rd_ok, ctrl_wr;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    wd_expire;

  // Address bits above the decoded byte offset and the burst hints are
  // intentionally ignored; every access is decoded as a classic cycle.
  logic                    unused_inputs;
  assign unused_inputs = ^{wb_adr_i, wb_cti_i, wb_bte_i};

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [SEL_W-1:0]      sel
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < SEL_W; b++) begin
      if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Bus decode. A new request is only taken while no response is showing,
  // which gives the mandatory one-cycle gap between back-to-back responses.
  // -------------------------------------------------------------------------
  always_comb begin
    req     = wb_cyc_i & wb_stb_i & ~(ack_q | err_q | rty_q);
    off     = wb_adr_i[7:0];
    idx     = off[5:2];
    is_ctrl = (off == 8'h00);
    is_stat = (off == 8'h04);
    is_in   = (off[7:6] == 2'b01) && (off[1:0] == 2'b00) &&
              ({1'b0, idx} < 5'(IN_WORDS));
    is_out  = (off[7:6] == 2'b10) && (off[1:0] == 2'b00) &&
              ({1'b0, idx} < 5'(OUT_WORDS));
    bad_acc = ~(is_ctrl | is_stat | is_in | is_out) |
              (wb_we_i & (is_stat | is_out));
    in_busy_wr = wb_we_i & is_in & (state_q == ST_RUN);

    ack_d   = req & ~bad_acc & ~in_busy_wr;
    err_d   = req & bad_acc;
    rty_d   = req & ~bad_acc & in_busy_wr;
    wr_ok   = ack_d & wb_we_i;
    rd_ok   = ack_d & ~wb_we_i;
    // START/IRQ_EN/CLR all live in byte lane 0
    ctrl_wr = wr_ok & is_ctrl & wb_sel_i[0];
  end

  // Read data mux
  always_comb begin
    rdata = '0;
    if (is_ctrl) begin
      rdata[1] = irq_en_q;
    end else if (is_stat) begin
      rdata[0] = (state_q == ST_RUN);
      rdata[1] = done_q;
      rdata[2] = timeout_q;
    end else if (is_in) begin
      for (int i = 0; i < IN_WORDS; i++) begin
        if (idx == 4'(i)) rdata = in_q[i];
      end
    end else if (is_out) begin
      for (int i = 0; i < OUT_WORDS; i++) begin
        if (idx == 4'(i)) rdata = out_q[i];
      end
    end
    dat_d = rd_ok ? rdata : '0;
  end

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
`ifdef WB_ACCEL_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wdog_q, wdog_d;

  // The counter holds the number of RUN cycles already elapsed, so the
  // expiry cycle is the TIMEOUT_CYCLES-th cycle spent in RUN.
  assign wd_expire = (state_q == ST_RUN) && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdog_d = wdog_q;
    if (start_pend_q) begin
      wdog_d = '0;
    end else if ((state_q == ST_RUN) && !wd_expire) begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) wdog_q <= '0;
    else            wdog_q <= wdog_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Control FSM and register bank next-state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    irq_en_d     = irq_en_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    start_pend_d = 1'b0;
    core_start_d = 1'b0;
    in_d         = in_q;
    out_d        = out_q;

    if (ctrl_wr) irq_en_d = wb_dat_i[1];

    if (wr_ok && is_in) begin
      for (int i = 0; i < IN_WORDS; i++) begin
        if (idx == 4'(i)) in_d[i] = byte_merge(in_q[i], wb_dat_i, wb_sel_i);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_wr && wb_dat_i[0]) start_pend_d = 1'b1;
      end
      ST_RUN: begin
        // A completion in the expiry cycle takes priority over the watchdog
        if (core_done_i) begin
          for (int i = 0; i < OUT_WORDS; i++) begin
            out_d[i] = core_dout_i[i*DATA_WIDTH +: DATA_WIDTH];
          end
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (wd_expire) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (ctrl_wr && wb_dat_i[0]) begin
          start_pend_d = 1'b1;
        end else if (ctrl_wr && wb_dat_i[2]) begin
          state_d   = ST_IDLE;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // START is latched at the ack edge and takes effect one cycle later, so
    // the core sees its start pulse in the cycle following the ack.
    if (start_pend_q) begin
      state_d      = ST_RUN;
      done_d       = 1'b0;
      timeout_d    = 1'b0;
      core_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q      <= ST_IDLE;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      start_pend_q <= 1'b0;
      core_start_q <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      rty_q        <= 1'b0;
      dat_q        <= '0;
      for (int i = 0; i < IN_WORDS; i++)  in_q[i]  <= '0;
      for (int i = 0; i < OUT_WORDS; i++) out_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      start_pend_q <= start_pend_d;
      core_start_q <= core_start_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rty_q        <= rty_d;
      dat_q        <= dat_d;
      in_q         <= in_d;
      out_q        <= out_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < IN_WORDS; i++) begin
      core_din_o[i*DATA_WIDTH +: DATA_WIDTH] = in_q[i];
    end
  end

  assign wb_dat_o     = dat_q;
  assign wb_ack_o     = ack_q;
  assign wb_err_o     = err_q;
  assign wb_rty_o     = rty_q;
  assign irq_o        = done_q & irq_en_q;
  assign core_start_o = core_start_q;

endmodule
